score_sweep_ctrl: RTL and testbench
===================================

// Module: score_sweep_ctrl
//
// PURPOSE
//   Sequencer that exhaustively exercises the 4-input "score" evaluator.
//   The evaluator is a separate combinational unit; score=1 iff popcount(i) is in [LO,HI].
//   This block sits between a host (start/abort) and that unit.
//   It drives all 16 input codes in order, waits for settling, and samples the unit's output.
//   It compares each sample against an internal reference model and reports counts and the first failing code.
//
// PARAMETERS
//   SETTLE  1  cycles each code is held before sampling; legal range 1..15
//   LO      2  lower popcount bound of the reference model (inclusive)
//   HI      3  upper popcount bound of the reference model (inclusive); LO <= HI <= 4
//
// PORTS
//   clk              in   1  single clock, rising edge
//   rst              in   1  asynchronous, active-high reset
//   start            in   1  pulse; begins a sweep when not busy
//   abort            in   1  pulse; stops a sweep, returns to IDLE
//   dut_i            out  4  code driven to the evaluator input
//   dut_score        in   1  evaluator output
//   busy             out  1  sweep in progress
//   done             out  1  sweep finished; held until next start or abort
//   pass             out  1  valid with done: 1 iff err_count==0
//   hit_count        out  5  number of codes where dut_score was 1 (0..16)
//   err_count        out  5  number of codes where dut_score != model (0..16)
//   first_err        out  4  lowest code that mismatched
//   first_err_valid  out  1  first_err holds a real mismatch
//
// BEHAVIOUR
//   - Reset (async, immediate, no clock needed):
//     - state=IDLE
//     - all outputs 0, including dut_i=4'h0
//     - settle counter 0
//   - FSM states:
//     - IDLE: wait for start.
//     - DRIVE: hold dut_i=code for SETTLE cycles.
//     - SAMPLE: one cycle.
//     - DONE: result holding.
//   - IDLE/DONE + start: code=0, counters cleared, first_err=0, first_err_valid=0, done=0, pass=0, busy=1; go to DRIVE.
//   - DRIVE:
//     - dut_i=code, changes only on entry to DRIVE.
//     - After SETTLE cycles, go to SAMPLE; dut_i stays stable through SAMPLE.
//   - SAMPLE, on the clock edge that leaves SAMPLE:
//     - exp = (LO <= popcount(code) <= HI).
//     - hit_count += dut_score.
//     - If dut_score != exp: err_count += 1.
//     - On the first mismatch of the sweep only, also first_err=code and first_err_valid=1.
//     - If code==4'hF: go to DONE.
//     - Otherwise code += 1 and go to DRIVE.
//   - DONE: busy=0, done=1, pass=(err_count==0); dut_i holds 4'hF.
//   - Latency: start sampled at edge E gives busy=1 after E, and done=1 after edge E+16*(SETTLE+1).
//   - start while busy: ignored, no restart, no counter effect.
//   - abort, any state:
//     - Go to IDLE at the next edge; busy=0, done=0, pass=0.
//     - Counters and first_err retain their values; dut_i returns to 0.
//   - start and abort in the same cycle: abort wins, result IDLE.
//   - Counter width: 5 bits suffices (max 16); saturation is impossible by construction.
//   - dut_score is sampled only in SAMPLE; its value in any other state has no effect.
//
// TESTING
//   1. Correct evaluator model, SETTLE=1, start at edge 0:
//      -> done rises after edge 32
//      -> hit_count=10, err_count=0, pass=1, first_err_valid=0.
//   2. dut_score stuck at 0:
//      -> hit_count=0, err_count=10, first_err=4'h3, first_err_valid=1, pass=0.
//   3. Inverted evaluator:
//      -> err_count=16, hit_count=6, first_err=4'h0, pass=0.
//   4. Abort 10 cycles into a sweep:
//      -> next cycle IDLE, busy=0, done=0, dut_i=0.
//      -> a new start then yields the same results as scenario 1.
//   5. Repeated start during busy, then start+abort together:
//      -> first sweep unaffected by the repeated starts.
//      -> the combined pulse leaves the FSM in IDLE.
//   6. Assert rst mid-sweep between clock edges:
//      -> all outputs 0 immediately.
//      -> after release, FSM stays in IDLE until start.

Source files
------------

// File: rtl/score_sweep_if.sv
// Handshake/result bundle between the sweep sequencer and its host plus the evaluator under test.
interface score_sweep_if;
    logic       start;
    logic       abort;
    logic [3:0] dut_i;
    logic       dut_score;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] hit_count;
    logic [4:0] err_count;
    logic [3:0] first_err;
    logic       first_err_valid;

    modport master (
        output start, abort, dut_score,
        input  dut_i, busy, done, pass, hit_count, err_count, first_err, first_err_valid
    );

    modport slave (
        input  start, abort, dut_score,
        output dut_i, busy, done, pass, hit_count, err_count, first_err, first_err_valid
    );
endinterface

// File: rtl/score_sweep_ctrl.sv
// Sweeps all 16 codes through the combinational score evaluator, samples its output after
// SETTLE cycles per code and scores it against the popcount-window reference.
module score_sweep_ctrl #(
    parameter int SETTLE = 1,
    parameter int LO     = 2,
    parameter int HI     = 3
) (
    input  logic         clk,
    input  logic         rst,
    score_sweep_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [4:0] err_next;

    function automatic logic model_score(input logic [3:0] c);
        int pc;
        pc = 0;
        for (int k = 0; k < 4; k++) begin
            pc += int'(c[k]);
        end
        return (pc >= LO) && (pc <= HI);
    endfunction

    // dut_i doubles as the sweep code, so the reference is evaluated on what the unit actually sees
    always_comb begin
        mismatch = (bus.dut_score != model_score(bus.dut_i));
        err_next = bus.err_count + {4'd0, mismatch};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            settle_cnt          <= 4'd0;
            bus.dut_i           <= 4'h0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.hit_count       <= 5'd0;
            bus.err_count       <= 5'd0;
            bus.first_err       <= 4'h0;
            bus.first_err_valid <= 1'b0;
        end else if (bus.abort) begin
            // results of the interrupted sweep stay visible for inspection
            state      <= IDLE;
            settle_cnt <= 4'd0;
            bus.dut_i  <= 4'h0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.pass   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state               <= DRIVE;
                        settle_cnt          <= 4'd0;
                        bus.dut_i           <= 4'h0;
                        bus.busy            <= 1'b1;
                        bus.done            <= 1'b0;
                        bus.pass            <= 1'b0;
                        bus.hit_count       <= 5'd0;
                        bus.err_count       <= 5'd0;
                        bus.first_err       <= 4'h0;
                        bus.first_err_valid <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    bus.hit_count <= bus.hit_count + {4'd0, bus.dut_score};
                    bus.err_count <= err_next;
                    if (mismatch && !bus.first_err_valid) begin
                        bus.first_err       <= bus.dut_i;
                        bus.first_err_valid <= 1'b1;
                    end
                    if (bus.dut_i == 4'hF) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_next == 5'd0);
                    end else begin
                        bus.dut_i <= bus.dut_i + 4'd1;
                        state     <= DRIVE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_sweep_ctrl.sv
// Bench for score_sweep_ctrl: a table-driven evaluator response per code, scored by a popcount model.
module tb_score_sweep_ctrl;

    localparam int SETTLE = 1;
    localparam int LO     = 2;
    localparam int HI     = 3;
    localparam int SWEEP_EDGES = 16 * (SETTLE + 1);

    logic        clk;
    logic        rst;
    logic [15:0] resp;
    logic [15:0] correct_resp;
    int          n_checks;
    int          n_fail;

    score_sweep_if sif ();

    score_sweep_ctrl #(.SETTLE(SETTLE), .LO(LO), .HI(HI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    // evaluator stand-in: a lookup table over the driven code
    assign sif.dut_score = resp[sif.dut_i];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] resp;
        int          hit;
        int          err;
        int          fe;
        int          fev;
        int          pass;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic ref_exp(input int c);
        int pc;
        pc = $countones(4'(c));
        return (pc >= LO) && (pc <= HI);
    endfunction

    // outcome of scoring the first n codes of a response table
    function automatic void ref_model(input logic [15:0] r, input int n,
                                      output int hit, output int err,
                                      output int fe, output int fev);
        hit = 0; err = 0; fe = 0; fev = 0;
        for (int c = 0; c < n; c++) begin
            hit += int'(r[c]);
            if (r[c] != ref_exp(c)) begin
                err++;
                if (fev == 0) begin
                    fe  = c;
                    fev = 1;
                end
            end
        end
    endfunction

    task automatic sweep(input logic [15:0] r, input bit inject, output int n);
        resp = r;
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        check("busy_after_start", sif.busy, 1);
        check("done_after_start", sif.done, 0);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sif.done) break;
            sif.start = inject && (n == 5 || n == 13 || n == 20);
        end
        sif.start = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input int n, input string tag);
        check({tag, "_latency"}, n, SWEEP_EDGES);
        check({tag, "_hit"}, sif.hit_count, v.hit);
        check({tag, "_err"}, sif.err_count, v.err);
        check({tag, "_first_err"}, sif.first_err, v.fe);
        check({tag, "_first_err_valid"}, sif.first_err_valid, v.fev);
        check({tag, "_pass"}, sif.pass, v.pass);
        check({tag, "_busy"}, sif.busy, 0);
        check({tag, "_dut_i"}, sif.dut_i, 15);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, sif.busy, 0);
        check({tag, "_done"}, sif.done, 0);
        check({tag, "_pass"}, sif.pass, 0);
        check({tag, "_dut_i"}, sif.dut_i, 0);
        check({tag, "_hit"}, sif.hit_count, 0);
        check({tag, "_err"}, sif.err_count, 0);
        check({tag, "_first_err"}, sif.first_err, 0);
        check({tag, "_first_err_valid"}, sif.first_err_valid, 0);
    endtask

    initial begin
        int   n;
        int   hit, err, fe, fev;
        vec_t v;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sif.start = 1'b0;
        sif.abort = 1'b0;

        correct_resp = '0;
        for (int c = 0; c < 16; c++) correct_resp[c] = ref_exp(c);
        resp = correct_resp;

        vecs[0] = '{correct_resp,  10,  0, 0, 0, 1};
        vecs[1] = '{16'h0000,       0, 10, 3, 1, 0};
        vecs[2] = '{~correct_resp,  6, 16, 0, 1, 0};
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].resp = 16'($urandom);
            ref_model(vecs[i].resp, 16, hit, err, fe, fev);
            vecs[i].hit  = hit;
            vecs[i].err  = err;
            vecs[i].fe   = fe;
            vecs[i].fev  = fev;
            vecs[i].pass = (err == 0) ? 1 : 0;
        end

        // reset state, then idle after release
        #1;
        check_all_zero("reset");
        #11;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", sif.busy, 0);
        check("idle_done", sif.done, 0);

        // table-driven sweeps
        for (int i = 0; i < NVEC; i++) begin
            sweep(vecs[i].resp, 1'b0, n);
            check_vec(vecs[i], n, $sformatf("vec%0d", i));
        end

        // abort ten cycles into a sweep
        resp = correct_resp;
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sif.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.abort = 1'b0;
        ref_model(correct_resp, 5, hit, err, fe, fev);
        check("abort_busy", sif.busy, 0);
        check("abort_done", sif.done, 0);
        check("abort_pass", sif.pass, 0);
        check("abort_dut_i", sif.dut_i, 0);
        check("abort_hit_kept", sif.hit_count, hit);
        check("abort_err_kept", sif.err_count, err);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", sif.busy, 0);
        sweep(correct_resp, 1'b0, n);
        check_vec(vecs[0], n, "after_abort");

        // repeated starts while busy must not disturb the sweep
        sweep(vecs[1].resp, 1'b1, n);
        check_vec(vecs[1], n, "restart_ignored");

        // start and abort together from DONE: abort wins
        @(negedge clk);
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        check("start_abort_busy", sif.busy, 0);
        check("start_abort_done", sif.done, 0);
        check("start_abort_dut_i", sif.dut_i, 0);
        check("start_abort_err_kept", sif.err_count, 10);
        repeat (4) @(negedge clk);
        check("start_abort_idle", sif.busy, 0);
        check("start_abort_idle_dut_i", sif.dut_i, 0);

        // asynchronous reset between edges mid-sweep
        resp = 16'hFFFF;
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("pre_reset_hit", sif.hit_count, 3);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_busy", sif.busy, 0);
        check("post_reset_dut_i", sif.dut_i, 0);
        check("post_reset_hit", sif.hit_count, 0);
        sweep(correct_resp, 1'b0, n);
        v = vecs[0];
        check_vec(v, n, "post_reset_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
